// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct codes,
// state encoding, datapath select encodings and the instruction-class bit positions.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_GPR    = 2'd3;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_SLL  = 3'd3;
    localparam logic [2:0] ALU_SLLV = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_LUI  = 3'd6;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_ZEXT = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam int CLS_W       = 10;
    localparam int CLS_ALU     = 0;
    localparam int CLS_ORI     = 1;
    localparam int CLS_LUI     = 2;
    localparam int CLS_LW      = 3;
    localparam int CLS_SW      = 4;
    localparam int CLS_BEQ     = 5;
    localparam int CLS_J       = 6;
    localparam int CLS_JAL     = 7;
    localparam int CLS_JR      = 8;
    localparam int CLS_ILLEGAL = 9;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: one-hot class vector plus the ALU
// operation implied by an R-type funct field.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    output logic [CLS_W-1:0] cls,
    output logic [2:0]       rtype_alu_op
);

    // Classify opcode/funct; anything unrecognised is marked illegal.
    always_comb begin
        cls          = '0;
        rtype_alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  begin cls[CLS_ALU] = 1'b1; rtype_alu_op = ALU_ADD;  end
                    FN_SUB:  begin cls[CLS_ALU] = 1'b1; rtype_alu_op = ALU_SUB;  end
                    FN_SLL:  begin cls[CLS_ALU] = 1'b1; rtype_alu_op = ALU_SLL;  end
                    FN_SLLV: begin cls[CLS_ALU] = 1'b1; rtype_alu_op = ALU_SLLV; end
                    FN_SLT:  begin cls[CLS_ALU] = 1'b1; rtype_alu_op = ALU_SLT;  end
                    FN_JR:   cls[CLS_JR]      = 1'b1;
                    default: cls[CLS_ILLEGAL] = 1'b1;
                endcase
            end
            OP_ORI:  cls[CLS_ORI]     = 1'b1;
            OP_LUI:  cls[CLS_LUI]     = 1'b1;
            OP_LW:   cls[CLS_LW]      = 1'b1;
            OP_SW:   cls[CLS_SW]      = 1'b1;
            OP_BEQ:  cls[CLS_BEQ]     = 1'b1;
            OP_J:    cls[CLS_J]       = 1'b1;
            OP_JAL:  cls[CLS_JAL]     = 1'b1;
            default: cls[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and selects, and counts retired instructions.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Func,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemToReg,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic [CLS_W-1:0]   cls_s;
    logic [2:0]         rtype_alu_op_s;
    logic               pc_write_s, ir_write_s, reg_write_s, mem_write_s;

    mc_decode u_decode (
        .opcode       (Opcode),
        .func         (Func),
        .cls          (cls_s),
        .rtype_alu_op (rtype_alu_op_s)
    );

    // Next-state and raw (ungated) control outputs from state and decoded class.
    always_comb begin
        state_d     = state_q;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        PCSrc       = PC_PLUS4;
        ALUOp       = ALU_ADD;
        ALUSrcB     = SRCB_RT;
        RegDst      = DST_RT;
        MemToReg    = M2R_ALU;
        case (state_q)
            ST_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls_s[CLS_J]) begin
                    pc_write_s = 1'b1;
                    PCSrc      = PC_JUMP;
                    state_d    = ST_FETCH;
                end else if (cls_s[CLS_JAL]) begin
                    pc_write_s  = 1'b1;
                    PCSrc       = PC_JUMP;
                    reg_write_s = 1'b1;
                    RegDst      = DST_RA;
                    MemToReg    = M2R_PC;
                    state_d     = ST_FETCH;
                end else if (cls_s[CLS_JR]) begin
                    pc_write_s = 1'b1;
                    PCSrc      = PC_GPR;
                    state_d    = ST_FETCH;
                end else if (cls_s[CLS_ILLEGAL]) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Zero only gates the branch write; the next state never depends on it.
                if (cls_s[CLS_BEQ]) begin
                    ALUOp      = ALU_SUB;
                    PCSrc      = PC_BRANCH;
                    pc_write_s = Zero;
                    state_d    = ST_FETCH;
                end else if (cls_s[CLS_LW] | cls_s[CLS_SW]) begin
                    ALUSrcB = SRCB_SEXT;
                    state_d = ST_MEM;
                end else if (cls_s[CLS_ORI]) begin
                    ALUOp   = ALU_OR;
                    ALUSrcB = SRCB_ZEXT;
                    state_d = ST_WB;
                end else if (cls_s[CLS_LUI]) begin
                    ALUOp   = ALU_LUI;
                    ALUSrcB = SRCB_ZEXT;
                    state_d = ST_WB;
                end else begin
                    ALUOp   = rtype_alu_op_s;
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (cls_s[CLS_SW]) begin
                    mem_write_s = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                RegDst      = cls_s[CLS_ALU] ? DST_RD : DST_RT;
                MemToReg    = cls_s[CLS_LW] ? M2R_MEM : M2R_ALU;
                state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign PCWrite    = pc_write_s  & ~reset;
    assign IRWrite    = ir_write_s  & ~reset;
    assign RegWrite   = reg_write_s & ~reset;
    assign MemWrite   = mem_write_s & ~reset;
    assign instr_done = (state_d == ST_FETCH) & ~reset;

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_comb begin
        instr_count_d = instr_count_q + (instr_done ? CNT_W'(1) : CNT_W'(0));
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
    assign state       = state_q;

endmodule
